// File: rtl/video_timing_pkg.sv
// Shared types and default 800x600 timing for the test-pattern video source.
package video_timing_pkg;

  typedef enum logic [1:0] {
    PAT_HRAMP = 2'd0,
    PAT_VRAMP = 2'd1,
    PAT_BARS  = 2'd2,
    PAT_CHECK = 2'd3
  } pat_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int DEF_H_SYNC  = 128;
  localparam int DEF_H_BACK  = 88;
  localparam int DEF_H_DISP  = 800;
  localparam int DEF_H_FRONT = 40;
  localparam int DEF_V_SYNC  = 4;
  localparam int DEF_V_BACK  = 23;
  localparam int DEF_V_DISP  = 600;
  localparam int DEF_V_FRONT = 1;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/video_timing_core.sv
// Frame sequencer: begin edge detect, sticky stop, RUN/IDLE FSM and the
// column/row counters that every other output is derived from.
module video_timing_core
  import video_timing_pkg::*;
#(
  parameter int H_SYNC  = DEF_H_SYNC,
  parameter int H_BACK  = DEF_H_BACK,
  parameter int H_DISP  = DEF_H_DISP,
  parameter int H_FRONT = DEF_H_FRONT,
  parameter int V_SYNC  = DEF_V_SYNC,
  parameter int V_BACK  = DEF_V_BACK,
  parameter int V_DISP  = DEF_V_DISP,
  parameter int V_FRONT = DEF_V_FRONT,
  localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT,
  localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT,
  localparam int CW      = $clog2(H_TOTAL),
  localparam int RW      = $clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          vout_begin,
  input  logic          vout_stop,
  input  logic          cont_mode,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic          run,
  output logic          active,
  output logic          frame_start,
  output logic          frame_end
);

  localparam logic [CW-1:0] H_LAST  = CW'(H_TOTAL - 1);
  localparam logic [RW-1:0] V_LAST  = RW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_BEG_C = CW'(H_SYNC + H_BACK);
  localparam logic [CW-1:0] H_END_C = CW'(H_SYNC + H_BACK + H_DISP - 1);
  localparam logic [RW-1:0] V_BEG_C = RW'(V_SYNC + V_BACK);
  localparam logic [RW-1:0] V_END_C = RW'(V_SYNC + V_BACK + V_DISP - 1);

  state_e        state_reg, state_next;
  logic [CW-1:0] col_reg;
  logic [RW-1:0] row_reg;
  logic          begin_d_reg;
  logic          cont_reg;
  logic          stop_pend_reg;
  logic          begin_edge;
  logic          at_end;
  logic          h_act, v_act;

  assign begin_edge = vout_begin & ~begin_d_reg;
  assign at_end     = (col_reg == H_LAST) && (row_reg == V_LAST);
  assign h_act      = (col_reg >= H_BEG_C) && (col_reg <= H_END_C);
  assign v_act      = (row_reg >= V_BEG_C) && (row_reg <= V_END_C);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // A begin edge seen while running is deliberately not looked at.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (begin_edge) state_next = ST_RUN;
      ST_RUN:  if (at_end && !(cont_reg && !stop_pend_reg)) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    run         = (state_reg == ST_RUN);
    frame_start = run && (col_reg == '0) && (row_reg == '0);
    frame_end   = run && at_end;
    active      = run && h_act && v_act;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_reg <= '0;
      row_reg <= '0;
    end else if (run) begin
      if (col_reg == H_LAST) begin
        col_reg <= '0;
        row_reg <= (row_reg == V_LAST) ? '0 : row_reg + 1'b1;
      end else begin
        col_reg <= col_reg + 1'b1;
      end
    end else begin
      col_reg <= '0;
      row_reg <= '0;
    end
  end

  // Stop is only heard while running, so a stop arriving with begin in IDLE is lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      begin_d_reg   <= 1'b0;
      cont_reg      <= 1'b0;
      stop_pend_reg <= 1'b0;
    end else begin
      begin_d_reg <= vout_begin;
      if (frame_start) begin
        cont_reg <= cont_mode;
      end
      if (!run || (state_next == ST_IDLE)) begin
        stop_pend_reg <= 1'b0;
      end else if (vout_stop) begin
        stop_pend_reg <= 1'b1;
      end
    end
  end

  assign col = col_reg;
  assign row = row_reg;

endmodule

// File: rtl/video_pattern_gen.sv
// Hardware video source: timing core plus test-pattern datapath, with all
// sync, pixel and marker outputs registered one cycle behind the counters.
module video_pattern_gen
  import video_timing_pkg::*;
#(
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BACK   = DEF_H_BACK,
  parameter int H_DISP   = DEF_H_DISP,
  parameter int H_FRONT  = DEF_H_FRONT,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BACK   = DEF_V_BACK,
  parameter int V_DISP   = DEF_V_DISP,
  parameter int V_FRONT  = DEF_V_FRONT,
  parameter int CH       = 3,
  parameter int DW       = 8,
  parameter bit SYNC_POL = 1'b1,
  localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT,
  localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT,
  localparam int CW      = $clog2(H_TOTAL),
  localparam int RW      = $clog2(V_TOTAL)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   vout_begin,
  input  logic                   vout_stop,
  input  logic                   cont_mode,
  input  logic [1:0]             pat_sel,
  output logic                   vout_vsync,
  output logic                   vout_hsync,
  output logic                   vout_valid,
  output logic [CH-1:0][DW-1:0]  vout_dat,
  output logic                   vout_sof,
  output logic                   vout_eol,
  output logic                   vout_done,
  output logic                   vout_busy,
  output logic [15:0]            frame_cnt,
  output logic [15:0]            vout_xres,
  output logic [15:0]            vout_yres
);

  localparam int H_OFF = H_SYNC + H_BACK;
  localparam int V_OFF = V_SYNC + V_BACK;
  // x must be wide enough for the bar divide across the whole line.
  localparam int XW    = max_int(max_int(DW, 4), CW);
  localparam int YW    = max_int(DW, 4);
  localparam int BAR_W = max_int(H_DISP / 8, 1);

  localparam logic [CW-1:0] H_SYNC_C = CW'(H_SYNC);
  localparam logic [RW-1:0] V_SYNC_C = RW'(V_SYNC);
  localparam logic [CW-1:0] H_OFF_C  = CW'(H_OFF);
  localparam logic [RW-1:0] V_OFF_C  = RW'(V_OFF);
  localparam logic [CW-1:0] H_EOL_C  = CW'(H_OFF + H_DISP - 1);

  logic [CW-1:0]         col;
  logic [RW-1:0]         row;
  logic                  run, active, frame_start, frame_end;
  pat_e                  pat_reg;
  logic [XW-1:0]         x, bar_q;
  logic [YW-1:0]         y;
  logic [2:0]            bar_idx;
  logic [DW-1:0]         hramp, vramp, check_px;
  logic [CH-1:0][DW-1:0] pix_next;

  logic                  hsync_reg, vsync_reg, valid_reg;
  logic                  sof_reg, eol_reg, done_reg, busy_reg;
  logic [CH-1:0][DW-1:0] dat_reg;
  logic [15:0]           frame_cnt_reg;

  video_timing_core #(
    .H_SYNC  (H_SYNC),
    .H_BACK  (H_BACK),
    .H_DISP  (H_DISP),
    .H_FRONT (H_FRONT),
    .V_SYNC  (V_SYNC),
    .V_BACK  (V_BACK),
    .V_DISP  (V_DISP),
    .V_FRONT (V_FRONT)
  ) u_core (
    .clk         (clk),
    .rst         (rst),
    .vout_begin  (vout_begin),
    .vout_stop   (vout_stop),
    .cont_mode   (cont_mode),
    .col         (col),
    .row         (row),
    .run         (run),
    .active      (active),
    .frame_start (frame_start),
    .frame_end   (frame_end)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_reg <= PAT_HRAMP;
    end else if (frame_start) begin
      pat_reg <= pat_e'(pat_sel);
    end
  end

  // Coordinates are only meaningful inside the active window; outside it they wrap.
  assign x        = XW'(col) - XW'(H_OFF);
  assign y        = YW'(row) - YW'(V_OFF);
  assign bar_q    = x / XW'(BAR_W);
  assign bar_idx  = (bar_q > XW'(7)) ? 3'd7 : bar_q[2:0];
  assign hramp    = x[DW-1:0];
  assign vramp    = y[DW-1:0];
  assign check_px = {DW{x[3] ^ y[3]}};

  for (genvar gi = 0; gi < CH; gi++) begin : g_ch
    assign pix_next[gi] = (pat_reg == PAT_HRAMP) ? hramp :
                          (pat_reg == PAT_VRAMP) ? vramp :
                          (pat_reg == PAT_BARS)  ? {DW{bar_idx[gi % 3]}} :
                                                   check_px;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync_reg     <= ~SYNC_POL;
      vsync_reg     <= ~SYNC_POL;
      valid_reg     <= 1'b0;
      dat_reg       <= '0;
      sof_reg       <= 1'b0;
      eol_reg       <= 1'b0;
      done_reg      <= 1'b0;
      busy_reg      <= 1'b0;
      frame_cnt_reg <= '0;
    end else begin
      hsync_reg <= (run && (col < H_SYNC_C)) ? SYNC_POL : ~SYNC_POL;
      vsync_reg <= (run && (row < V_SYNC_C)) ? SYNC_POL : ~SYNC_POL;
      valid_reg <= active;
      dat_reg   <= active ? pix_next : '0;
      sof_reg   <= active && (col == H_OFF_C) && (row == V_OFF_C);
      eol_reg   <= active && (col == H_EOL_C);
      done_reg  <= frame_end;
      busy_reg  <= run;
      if (frame_end) begin
        frame_cnt_reg <= frame_cnt_reg + 16'd1;
      end
    end
  end

  assign vout_hsync = hsync_reg;
  assign vout_vsync = vsync_reg;
  assign vout_valid = valid_reg;
  assign vout_dat   = dat_reg;
  assign vout_sof   = sof_reg;
  assign vout_eol   = eol_reg;
  assign vout_done  = done_reg;
  assign vout_busy  = busy_reg;
  assign frame_cnt  = frame_cnt_reg;
  assign vout_xres  = 16'(H_DISP);
  assign vout_yres  = 16'(V_DISP);

endmodule

// File: tb/tb_video_pattern_gen.sv
// Directed bench for video_pattern_gen on a 14x7 frame (8x4 active), active-low syncs.
`timescale 1ns/1ps
module tb_video_pattern_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        vout_begin = 1'b0;
  logic        vout_stop = 1'b0;
  logic        cont_mode = 1'b0;
  logic [1:0]  pat_sel = 2'd0;
  logic        vout_vsync, vout_hsync, vout_valid;
  logic [2:0][7:0] vout_dat;
  logic        vout_sof, vout_eol, vout_done, vout_busy;
  logic [15:0] frame_cnt, vout_xres, vout_yres;

  int n_checks = 0;
  int n_errors = 0;
  int tcnt, pix_idx, n_valid, n_done, n_sof, n_eol, n_hs, n_vs, n_busy;
  int n_sof_bad, n_eol_bad, n_idle_bad, first_done, cur_pat;
  logic [23:0] cap3, cap5;
  logic hs_t1, busy_t1, busy_t0;

  video_pattern_gen #(
    .H_SYNC(2), .H_BACK(2), .H_DISP(8), .H_FRONT(2),
    .V_SYNC(1), .V_BACK(1), .V_DISP(4), .V_FRONT(1),
    .CH(3), .DW(8), .SYNC_POL(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .vout_begin(vout_begin), .vout_stop(vout_stop),
    .cont_mode(cont_mode), .pat_sel(pat_sel), .vout_vsync(vout_vsync),
    .vout_hsync(vout_hsync), .vout_valid(vout_valid), .vout_dat(vout_dat),
    .vout_sof(vout_sof), .vout_eol(vout_eol), .vout_done(vout_done),
    .vout_busy(vout_busy), .frame_cnt(frame_cnt), .vout_xres(vout_xres),
    .vout_yres(vout_yres)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected pixel for an 8x4 active area, idx = raster index within the frame.
  function automatic logic [23:0] exp_pix(input int pat, input int idx);
    int x, y;
    logic [7:0] xb, yb, cb;
    logic [2:0] b;
    x  = idx % 8;
    y  = (idx / 8) % 4;
    xb = 8'(x);
    yb = 8'(y);
    b  = 3'(x);
    cb = {8{xb[3] ^ yb[3]}};
    case (pat)
      0:       return {xb, xb, xb};
      1:       return {yb, yb, yb};
      2:       return {{8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
      default: return {cb, cb, cb};
    endcase
  endfunction

  task automatic clear_stats();
    pix_idx = 0; n_valid = 0; n_done = 0; n_sof = 0; n_eol = 0; n_hs = 0;
    n_vs = 0; n_busy = 0; n_sof_bad = 0; n_eol_bad = 0; n_idle_bad = 0;
    first_done = -1; tcnt = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    tcnt++;
    if (tcnt == 1) begin
      hs_t1   = vout_hsync;
      busy_t1 = vout_busy;
    end
    if (vout_valid) begin
      check($sformatf("pix%0d", pix_idx), 32'(vout_dat), 32'(exp_pix(cur_pat, pix_idx)));
      if (pix_idx == 3) cap3 = vout_dat;
      if (pix_idx == 5) cap5 = vout_dat;
      if (vout_sof != (pix_idx == 0)) n_sof_bad++;
      if (vout_eol != ((pix_idx % 8) == 7)) n_eol_bad++;
      pix_idx++;
      n_valid++;
    end else if ((vout_dat != '0) || vout_sof || vout_eol) begin
      n_idle_bad++;
    end
    if (vout_sof) n_sof++;
    if (vout_eol) n_eol++;
    if (!vout_hsync) n_hs++;
    if (!vout_vsync) n_vs++;
    if (vout_busy) n_busy++;
    if (vout_done) begin
      n_done++;
      if (first_done < 0) first_done = tcnt;
      pix_idx = 0;
      $display("frame done: t=%0d frame_cnt=%0d pat=%0d valid=%0d", tcnt, frame_cnt, cur_pat, n_valid);
    end
  endtask

  task automatic start(input logic cont, input int pat);
    cont_mode  = cont;
    pat_sel    = 2'(pat);
    cur_pat    = pat;
    vout_begin = 1'b1;
    tick();
    busy_t0    = vout_busy;
    vout_begin = 1'b0;
    tcnt       = 0;
  endtask

  task automatic wait_idle(input int bound);
    bit seen = 1'b0;
    bit idle = 1'b0;
    for (int k = 0; k < bound && !idle; k++) begin
      tick();
      if (vout_busy) seen = 1'b1;
      else if (seen) idle = 1'b1;
    end
    check("reach_idle", 32'(idle), 32'd1);
  endtask

  task automatic check_markers(input string tag);
    check({tag, "_sof_pos"}, 32'(n_sof_bad), 32'd0);
    check({tag, "_eol_pos"}, 32'(n_eol_bad), 32'd0);
    check({tag, "_idle_dat"}, 32'(n_idle_bad), 32'd0);
  endtask

  initial begin
    cur_pat = 0;
    clear_stats();
    #1 rst = 1'b1;
    #2;
    check("rst_hsync", 32'(vout_hsync), 32'd1);
    check("rst_vsync", 32'(vout_vsync), 32'd1);
    check("rst_valid", 32'(vout_valid), 32'd0);
    check("rst_dat", 32'(vout_dat), 32'd0);
    check("rst_markers", {29'd0, vout_sof, vout_eol, vout_done}, 32'd0);
    check("rst_busy", 32'(vout_busy), 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("xres", 32'(vout_xres), 32'd8);
    check("yres", 32'(vout_yres), 32'd4);
    @(posedge clk);
    #1 rst = 1'b0;

    // Single frame, horizontal ramp
    clear_stats();
    start(1'b0, 0);
    for (int k = 0; k < 200 && n_done == 0; k++) tick();
    check("done_latency", 32'(first_done), 32'd98);
    check("busy_at_done", 32'(vout_busy), 32'd1);
    tick();
    check("busy_fall", 32'(vout_busy), 32'd0);
    check("busy_t0", 32'(busy_t0), 32'd0);
    check("busy_t1", 32'(busy_t1), 32'd1);
    check("hsync_t1", 32'(hs_t1), 32'd0);
    check("s1_valid", 32'(n_valid), 32'd32);
    check("s1_done", 32'(n_done), 32'd1);
    check("s1_busy_cycles", 32'(n_busy), 32'd98);
    check("s1_frame_cnt", 32'(frame_cnt), 32'd1);
    check("s1_hsync_low", 32'(n_hs), 32'd14);
    check("s1_vsync_low", 32'(n_vs), 32'd14);
    check("s1_sof", 32'(n_sof), 32'd1);
    check("s1_eol", 32'(n_eol), 32'd4);
    check_markers("s1");

    // Continuous vertical ramp, stop requested during frame 3
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    clear_stats();
    start(1'b1, 1);
    for (int k = 0; k < 400 && n_done < 2; k++) tick();
    repeat (40) tick();
    vout_stop = 1'b1;
    tick();
    vout_stop = 1'b0;
    cont_mode = 1'b0;
    wait_idle(400);
    check("s2_done", 32'(n_done), 32'd3);
    check("s2_frame_cnt", 32'(frame_cnt), 32'd3);
    check("s2_busy_cycles", 32'(n_busy), 32'd294);
    check("s2_valid", 32'(n_valid), 32'd96);
    check("s2_sof", 32'(n_sof), 32'd3);
    check("s2_eol", 32'(n_eol), 32'd12);
    check_markers("s2");

    // Colour bars
    clear_stats();
    start(1'b0, 2);
    wait_idle(200);
    check("bars_x3", 32'(cap3), 32'h00_00FFFF);
    check("bars_x5", 32'(cap5), 32'h00_FF00FF);
    check("s3_done", 32'(n_done), 32'd1);
    check("s3_frame_cnt", 32'(frame_cnt), 32'd4);
    check_markers("s3");

    // Begin and stop in the same idle cycle: begin wins
    clear_stats();
    vout_stop = 1'b1;
    start(1'b0, 3);
    vout_stop = 1'b0;
    wait_idle(200);
    check("s4_done", 32'(n_done), 32'd1);
    check("s4_valid", 32'(n_valid), 32'd32);
    check("s4_frame_cnt", 32'(frame_cnt), 32'd5);

    // Begin re-pulsed mid-frame must not restart
    clear_stats();
    start(1'b0, 0);
    repeat (30) tick();
    vout_begin = 1'b1;
    tick();
    vout_begin = 1'b0;
    wait_idle(300);
    check("s5_busy_cycles", 32'(n_busy), 32'd98);
    check("s5_done", 32'(n_done), 32'd1);
    check("s5_valid", 32'(n_valid), 32'd32);
    check("s5_frame_cnt", 32'(frame_cnt), 32'd6);

    // Reset mid-line, then a normal frame
    clear_stats();
    start(1'b0, 1);
    repeat (35) tick();
    check("pre_rst_valid", 32'(vout_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(vout_valid), 32'd0);
    check("mid_rst_dat", 32'(vout_dat), 32'd0);
    check("mid_rst_busy", 32'(vout_busy), 32'd0);
    check("mid_rst_hsync", 32'(vout_hsync), 32'd1);
    check("mid_rst_vsync", 32'(vout_vsync), 32'd1);
    check("mid_rst_frame_cnt", 32'(frame_cnt), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    clear_stats();
    start(1'b0, 0);
    wait_idle(200);
    check("s6_done", 32'(n_done), 32'd1);
    check("s6_valid", 32'(n_valid), 32'd32);
    check("s6_frame_cnt", 32'(frame_cnt), 32'd1);
    check_markers("s6");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
